// File: rtl/pipe_stage_register.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer and flush.
// ready_o comes straight from a flop, so no combinational ready path crosses the stage.
module pipe_stage_register #(
  parameter int unsigned     Size       = 1,
  parameter logic [Size-1:0] ResetValue = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Size-1:0] data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [Size-1:0] data_o,
  output logic            valid_o,
  input  logic            ready_i,
  input  logic            flush,
  output logic [1:0]      count_o
);

  localparam int unsigned CountW = 2;

  // State encoding doubles as the occupancy count.
  typedef enum logic [CountW-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic [Size-1:0] main_q, main_d;
  logic [Size-1:0] skid_q, skid_d;
  logic            accept_c;
  logic            drain_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      main_q  <= ResetValue;
      skid_q  <= ResetValue;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept_c = valid_i & ready_q;
    drain_c  = valid_q & ready_i;

    unique case (state_q)
      EMPTY: begin
        if (accept_c) begin
          main_d  = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept_c && drain_c) begin
          main_d = data_i;
        end else if (drain_c) begin
          state_d = EMPTY;
        end else if (accept_c) begin
          skid_d  = data_i;
          state_d = TWO;
        end
      end
      TWO: begin
        // Skid entry is younger, so it only moves up once main has drained.
        if (drain_c) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides any state change; data registers are left as don't-care.
    if (flush) begin
      state_d = EMPTY;
    end

    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = main_q;
  assign count_o = CountW'(state_q);

endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: directed scenarios plus random traffic, checked by a
// reference-queue scoreboard that pops on every observed downstream transfer.
module tb_pipe_stage_register;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic         flush;
  logic [1:0]   count_o;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  pipe_stage_register #(
    .Size      (W),
    .ResetValue(8'hA5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .flush  (flush),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: at each negedge compare outputs against the reference queue, then
  // apply the transfers that the coming rising edge will perform.
  task automatic monitor();
    logic [W-1:0] exp_d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        chk("count", 32'(count_o), 32'(exp_q.size()));
        chk("valid", 32'(valid_o), 32'(exp_q.size() != 0));
        chk("ready", 32'(ready_o), 32'(exp_q.size() < 2));
        if (valid_o && ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(data_o), 32'hFFFF_FFFF);
          end else begin
            exp_d = exp_q.pop_front();
            chk("data_order", 32'(data_o), 32'(exp_d));
          end
        end
        if (flush) exp_q.delete();
        else if (valid_i && ready_o) exp_q.push_back(data_i);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush   = f;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'hA5);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    step();

    // Streaming: one transfer per cycle, each word visible the cycle after its accept.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      chk("stream_data", 32'(data_o), 32'(i));
      chk("stream_count", 32'(count_o), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("stream_empty", 32'(count_o), 32'd0);

    // Stall and skid: two accepts with downstream stalled.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    step();
    chk("skid_count", 32'(count_o), 32'd2);
    chk("skid_ready", 32'(ready_o), 32'd0);
    chk("skid_data", 32'(data_o), 32'h11);

    // Ready hold: 0x33 offered while full must not transfer.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h33, 1'b0, 1'b0);
      step();
      chk("hold_count", 32'(count_o), 32'd2);
      chk("hold_data", 32'(data_o), 32'h11);
    end
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    step();
    chk("drain1_data", 32'(data_o), 32'h22);
    chk("drain1_ready", 32'(ready_o), 32'd1);
    chk("drain1_count", 32'(count_o), 32'd1);
    step();
    chk("drain2_data", 32'(data_o), 32'h33);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("drain3_valid", 32'(valid_o), 32'd0);

    // Flush while full, with 0x44 offered in the same cycle.
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hBB, 1'b0, 1'b0);
    step();
    chk("pre_flush_count", 32'(count_o), 32'd2);
    drive(1'b1, 8'h44, 1'b0, 1'b1);
    step();
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step();

    // Asynchronous reset mid-cycle with two entries held.
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'hA5);
    #10;
    rst_n = 1'b1;
    step();

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 5);
      step();
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) step();
    chk("final_empty", 32'(count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
